// File: rtl/audio_avg_filter.sv
// N-tap moving-average filter between the codec read and write ports, both channels in parallel.
// Optional `AVG_FILTER_BYPASS_EN adds a "bypass" input that routes the raw latched sample to the output.
module audio_avg_filter #(
   parameter int DATA_W = 24,
   parameter int LOG2_N = 3
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic              read_ready,
   input  logic              write_ready,
   input  logic [DATA_W-1:0] readdata_left,
   input  logic [DATA_W-1:0] readdata_right,
`ifdef AVG_FILTER_BYPASS_EN
   input  logic              bypass,
`endif
   output logic              read,
   output logic              write,
   output logic [DATA_W-1:0] writedata_left,
   output logic [DATA_W-1:0] writedata_right
);

   localparam int unsigned N = 1 << LOG2_N;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_WRITE} state_t;

   state_t                    r_state;
   logic signed [DATA_W-1:0]  r_samp_l, r_samp_r;
   logic signed [DATA_W-1:0]  r_acc_l, r_acc_r;
   logic signed [DATA_W-1:0]  r_hist_l [N];
   logic signed [DATA_W-1:0]  r_hist_r [N];
   logic        [LOG2_N-1:0]  r_ptr;
   logic        [DATA_W-1:0]  r_wdata_l, r_wdata_r;

   logic signed [DATA_W-1:0]  w_scaled_l, w_scaled_r;
   logic signed [DATA_W-1:0]  w_acc_l, w_acc_r;
   logic                      w_bypass;

`ifdef AVG_FILTER_BYPASS_EN
   assign w_bypass = bypass;
`else
   assign w_bypass = 1'b0;
`endif

   // Each sample is floored before summing, so the running sum of N terms stays in range.
   assign w_scaled_l = r_samp_l >>> LOG2_N;
   assign w_scaled_r = r_samp_r >>> LOG2_N;
   assign w_acc_l    = r_acc_l + w_scaled_l - r_hist_l[r_ptr];
   assign w_acc_r    = r_acc_r + w_scaled_r - r_hist_r[r_ptr];

   assign read            = (r_state == S_IDLE)  && read_ready && write_ready;
   assign write           = (r_state == S_WRITE) && write_ready;
   assign writedata_left  = r_wdata_l;
   assign writedata_right = r_wdata_r;

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_samp_l  <= '0;
         r_samp_r  <= '0;
         r_acc_l   <= '0;
         r_acc_r   <= '0;
         r_ptr     <= '0;
         r_wdata_l <= '0;
         r_wdata_r <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            r_hist_l[i] <= '0;
            r_hist_r[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (read) begin
                  r_samp_l <= readdata_left;
                  r_samp_r <= readdata_right;
                  r_state  <= S_ACC;
               end
            end
            S_ACC: begin
               r_acc_l         <= w_acc_l;
               r_acc_r         <= w_acc_r;
               r_hist_l[r_ptr] <= w_scaled_l;
               r_hist_r[r_ptr] <= w_scaled_r;
               r_ptr           <= r_ptr + 1'b1;
               r_wdata_l       <= w_bypass ? r_samp_l : w_acc_l;
               r_wdata_r       <= w_bypass ? r_samp_r : w_acc_r;
               r_state         <= S_WRITE;
            end
            S_WRITE: begin
               // Output tracks bypass while stalled, then is frozen from the write onward.
               if (write_ready) begin
                  r_state <= S_IDLE;
               end else begin
                  r_wdata_l <= w_bypass ? r_samp_l : r_acc_l;
                  r_wdata_r <= w_bypass ? r_samp_r : r_acc_r;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_avg_filter.sv
// Scoreboard bench for audio_avg_filter: a driver pushes model results on each read strobe,
// a monitor pops and compares on each write strobe.
module tb_audio_avg_filter;

   localparam int DATA_W = 24;
   localparam int LOG2_N = 3;
   localparam int N      = 1 << LOG2_N;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              read_ready, write_ready;
   logic [DATA_W-1:0] readdata_left, readdata_right;
   logic              read, write;
   logic [DATA_W-1:0] writedata_left, writedata_right;
`ifdef AVG_FILTER_BYPASS_EN
   logic              bypass = 1'b0;
`endif

   always #5 clk = ~clk;

   audio_avg_filter #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
      .CLOCK_50        (clk),
      .reset_n         (reset_n),
      .read_ready      (read_ready),
      .write_ready     (write_ready),
      .readdata_left   (readdata_left),
      .readdata_right  (readdata_right),
`ifdef AVG_FILTER_BYPASS_EN
      .bypass          (bypass),
`endif
      .read            (read),
      .write           (write),
      .writedata_left  (writedata_left),
      .writedata_right (writedata_right)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_read_cyc = 0;
   bit lat_en   = 1'b0;
   bit model_bypass = 1'b0;
   bit prev_read = 1'b0, prev_write = 1'b0;

   int exp_l[$], exp_r[$];
   int hist_l[$], hist_r[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int to_int(input logic [DATA_W-1:0] v);
      return int'($signed(v));
   endfunction

   // Floor division by N using plain integer arithmetic.
   function automatic int floor_div(input int x);
      return (x - (((x % N) + N) % N)) / N;
   endfunction

   function automatic int sum_q(input int q[$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      return s;
   endfunction

   task automatic model_clear();
      hist_l.delete();
      hist_r.delete();
      for (int i = 0; i < N; i++) begin
         hist_l.push_back(0);
         hist_r.push_back(0);
      end
   endtask

   task automatic model_push(input int l, input int r);
      hist_l.push_back(floor_div(l)); void'(hist_l.pop_front());
      hist_r.push_back(floor_div(r)); void'(hist_r.pop_front());
      exp_l.push_back(model_bypass ? l : sum_q(hist_l));
      exp_r.push_back(model_bypass ? r : sum_q(hist_r));
   endtask

   always @(posedge clk) cyc++;

   // Monitor
   always @(negedge clk) begin
      if (read || write) check("read_write_exclusive", int'(read && write), 0);
      if (read && prev_read)   check("read_single_pulse", 1, 0);
      if (write && prev_write) check("write_single_pulse", 1, 0);
      if (write) begin
         if (exp_l.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            check("writedata_left",  to_int(writedata_left),  exp_l.pop_front());
            check("writedata_right", to_int(writedata_right), exp_r.pop_front());
            if (lat_en) check("latency", cyc - last_read_cyc, 2);
         end
      end
      prev_read  = read;
      prev_write = write;
   end

   task automatic send(input int l, input int r, input bit rnd);
      bit done = 1'b0;
      @(posedge clk); #1;
      readdata_left  = DATA_W'(l);
      readdata_right = DATA_W'(r);
      read_ready     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      write_ready    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (read) begin
            last_read_cyc = cyc;
            model_push(l, r);
            done = 1'b1;
         end else begin
            @(posedge clk); #1;
            if (rnd) begin
               read_ready  = ($urandom_range(0, 3) != 0);
               write_ready = ($urandom_range(0, 3) != 0);
            end
         end
      end
      if (!done) check("read_timeout", 0, 1);
   endtask

   task automatic drain();
      @(posedge clk); #1;
      read_ready  = 1'b0;
      write_ready = 1'b1;
      for (int i = 0; i < 20 && exp_l.size() != 0; i++) @(negedge clk);
      check("drain_empty", exp_l.size(), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n     = 1'b0;
      read_ready  = 1'b0;
      write_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      exp_l.delete();
      exp_r.delete();
      model_clear();
   endtask

   task automatic check_idle_outputs(input string name);
      @(negedge clk);
      check({name, "_read"},  int'(read),  0);
      check({name, "_write"}, int'(write), 0);
      check({name, "_wdl"},   to_int(writedata_left),  0);
      check({name, "_wdr"},   to_int(writedata_right), 0);
   endtask

   initial begin
      reset_n = 1'b0; read_ready = 1'b0; write_ready = 1'b0;
      readdata_left = '0; readdata_right = '0;
      model_clear();
      do_reset();
      check_idle_outputs("reset");

      // DC step, full-rate handshake with latency check
      lat_en = 1'b1;
      for (int i = 0; i < 10; i++) send(800, 800, 1'b0);
      drain();

      // Negative inputs and floor behaviour
      do_reset();
      for (int i = 0; i < 9; i++) send(-1, -1, 1'b0);
      drain();
      do_reset();
      for (int i = 0; i < 8; i++) send(-8, -8, 1'b0);
      drain();

      // Impulse: eight writes of 1000 then 0, exercising pointer wrap
      do_reset();
      send(8000, -8000, 1'b0);
      for (int i = 0; i < 9; i++) send(0, 0, 1'b0);
      drain();
      lat_en = 1'b0;

      // Back-pressure held for 5 cycles in S_WRITE
      do_reset();
      send(800, 1600, 1'b0);
      @(posedge clk); #1 write_ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_write_low", int'(write), 0);
         check("bp_read_low",  int'(read),  0);
         check("bp_wdl_stable", to_int(writedata_left),  exp_l[0]);
         check("bp_wdr_stable", to_int(writedata_right), exp_r[0]);
         @(posedge clk); #1;
      end
      write_ready = 1'b1;
      drain();

      // Reset while in S_ACC aborts the pending write and clears history
      do_reset();
      for (int i = 0; i < 4; i++) send(800, 800, 1'b0);
      drain();
      send(800, 800, 1'b0);
      void'(exp_l.pop_back());
      void'(exp_r.pop_back());
      @(posedge clk); #1;
      reset_n = 1'b0; read_ready = 1'b0; write_ready = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      model_clear();
      write_ready = 1'b1;
      for (int i = 0; i < 3; i++) check_idle_outputs("midop_reset");
      send(800, 800, 1'b0);
      drain();
      check("midop_ramp_restart", to_int(writedata_left), 100);

`ifdef AVG_FILTER_BYPASS_EN
      do_reset();
      bypass = 1'b1; model_bypass = 1'b1;
      send(800, 800, 1'b0);
      drain();
      bypass = 1'b0; model_bypass = 1'b0;
      send(800, 800, 1'b0);
      drain();
`endif

      // Randomized data and handshake timing
      do_reset();
      for (int i = 0; i < 200; i++) begin
         logic [DATA_W-1:0] vl, vr;
         vl = DATA_W'($urandom);
         vr = DATA_W'($urandom);
         send(to_int(vl), to_int(vr), 1'b1);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
